tmds_decoder: RTL

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: two-stage pipeline with control-token word alignment.
// Hunts for a run of control tokens, requests bitslips while misaligned, and drops lock after a long token-free gap.
module tmds_decoder #(
    parameter int unsigned TOKEN_RUN  = 8,
    parameter int unsigned SEARCH_WIN = 2048,
    parameter int unsigned SLIP_WAIT  = 16,
    parameter int unsigned LOCK_WIN   = 4096
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [9:0] tmds_data_in,
    output logic       bitslip,
    output logic       aligned,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic [7:0] data_out
);

    localparam int unsigned RUN_W  = (TOKEN_RUN  > 1) ? $clog2(TOKEN_RUN)  : 1;
    localparam int unsigned WIN_W  = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
    localparam int unsigned WAIT_W = (SLIP_WAIT  > 1) ? $clog2(SLIP_WAIT)  : 1;
    localparam int unsigned GAP_W  = (LOCK_WIN   > 1) ? $clog2(LOCK_WIN)   : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LOCK_WIN - 1);

    typedef enum logic [1:0] {
        SEARCH,
        SLIP,
        WAIT,
        LOCKED
    } state_t;

    state_t            state;
    logic [1:0]        rst_sync;
    logic              rst_n_int;
    logic [9:0]        s1_word;
    logic              tok_hit;
    logic [1:0]        tok_c;
    logic [RUN_W-1:0]  run_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    // Assertion is immediate; release reaches the rest of the logic two edges later.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q    = '0;
        q[0] = d[0];
        for (int unsigned i = 1; i < 8; i++) begin
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    always_comb begin
        tok_hit = 1'b1;
        tok_c   = 2'b00;
        case (s1_word)
            10'b1101010100: tok_c = 2'b00;
            10'b0010101011: tok_c = 2'b01;
            10'b0101010100: tok_c = 2'b10;
            10'b1010101011: tok_c = 2'b11;
            default:        tok_hit = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            s1_word <= '0;
        end else begin
            s1_word <= tmds_data_in;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state    <= SEARCH;
            run_cnt  <= '0;
            win_cnt  <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            bitslip  <= 1'b0;
            aligned  <= 1'b0;
            de       <= 1'b0;
            c0       <= 1'b0;
            c1       <= 1'b0;
            data_out <= '0;
        end else begin
            // Output stage decodes the stage-1 word under the lock state it arrived in.
            if (state == LOCKED) begin
                if (tok_hit) begin
                    de       <= 1'b0;
                    data_out <= '0;
                    c1       <= tok_c[1];
                    c0       <= tok_c[0];
                end else begin
                    de       <= 1'b1;
                    data_out <= tmds_decode(s1_word);
                end
            end else begin
                de       <= 1'b0;
                data_out <= '0;
                c1       <= 1'b0;
                c0       <= 1'b0;
            end

            bitslip <= 1'b0;
            case (state)
                SEARCH: begin
                    if (tok_hit && run_cnt == RUN_LAST) begin
                        state   <= LOCKED;
                        aligned <= 1'b1;
                        run_cnt <= '0;
                        win_cnt <= '0;
                        gap_cnt <= '0;
                    end else if (win_cnt == WIN_LAST) begin
                        state   <= SLIP;
                        bitslip <= 1'b1;
                        run_cnt <= '0;
                        win_cnt <= '0;
                    end else begin
                        run_cnt <= tok_hit ? run_cnt + 1'b1 : '0;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                SLIP: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state   <= SEARCH;
                        run_cnt <= '0;
                        win_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (tok_hit) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state   <= SEARCH;
                        aligned <= 1'b0;
                        gap_cnt <= '0;
                        run_cnt <= '0;
                        win_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule
